// File: rtl/calc_pkg.sv
// Shared definitions for the calculator slice: FSM state encoding and
// the default operand width / display limit used by seq_multiplier.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF    = 7;
  localparam int DISP_MAX_DEF = 9999;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier: one multiplier bit per clock, product
// registered on completion. Define SEQ_MULT_EARLY_TERM_EN to stop as soon as
// the remaining multiplier bits are all zero.
module seq_multiplier
  import calc_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DISP_MAX = DISP_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               start,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done,
  output logic               flag
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state;
  state_t          next_state;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   sum;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            over;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Accumulator value after the current RUN step; becomes P on the final step.
  always_comb begin
    sum  = acc + (mplier[0] ? mcand : '0);
    over = (64'(sum) > 64'(DISP_MAX));
`ifdef SEQ_MULT_EARLY_TERM_EN
    last = ((mplier >> 1) == '0);
`else
    last = (cnt == LAST_BIT);
`endif
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operands are captured once at start, so later A/B/start activity is invisible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      P      <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= sum;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            P    <= sum;
            flag <= over;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: the driver pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_multiplier;

  localparam int W    = 7;
  localparam int DMAX = 9999;

  typedef struct {
    logic [2*W-1:0] p;
    logic           f;
    int             lat;
    int             issue;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic           start = 1'b0;
  logic [2*W-1:0] P;
  logic           busy;
  logic           done;
  logic           flag;

  exp_t           q[$];
  int             cyc = 0;
  int             checks = 0;
  int             passes = 0;
  int             busyCnt = 0;
  logic [2*W-1:0] heldP = '0;
  logic           heldFlag = 1'b0;

  seq_multiplier #(.WIDTH(W), .DISP_MAX(DMAX)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .start(start),
    .P(P), .busy(busy), .done(done), .flag(flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference latency: fixed width, or the multiplier's bit-length when terminating early.
  function automatic int refLatency(input int b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int n = 0;
    while (b > 0) begin
      n++;
      b = b / 2;
    end
    return (n < 1) ? 1 : n;
`else
    return W;
`endif
  endfunction

  task automatic waitIdle();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!busy && !done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("idle_timeout", 0, 1);
  endtask

  // Issue one operation; when disturb is set, A/B/start are scrambled during RUN.
  task automatic applyStimulus(input int a, input int b, input bit disturb);
    exp_t e;
    A = W'(a); B = W'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.p = (2*W)'(a * b);
    e.f = (a * b) > DMAX;
    e.lat = refLatency(b);
    e.issue = cyc;
    q.push_back(e);
    if (disturb) begin
      A = 7'd9; B = 7'd9; start = 1'b1;
      @(posedge clk); #1;
      A = 7'd55; B = 7'd77;
      @(posedge clk); #1;
      start = 1'b0; A = 7'd1; B = 7'd1;
    end
    waitIdle();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_P"}, P, 0);
    checkOutput({tag, "_flag"}, flag, 0);
  endtask

  // Monitor: pops the scoreboard on done, otherwise checks that P/flag hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busyCnt = 0;
      end else begin
        if (busy) busyCnt++;
        if (done) begin
          if (q.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            checkOutput("product", P, e.p);
            checkOutput("flag", flag, e.f);
            checkOutput("latency", cyc - e.issue, e.lat);
            checkOutput("busy_cycles", busyCnt, e.lat);
            heldP = e.p;
            heldFlag = e.f;
          end
          busyCnt = 0;
        end else begin
          checkOutput("hold_P", P, heldP);
          checkOutput("hold_flag", flag, heldFlag);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ra, rb;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    applyStimulus(127, 127, 0);
    applyStimulus(99, 101, 0);
    applyStimulus(100, 100, 0);
    applyStimulus(5, 0, 0);
    applyStimulus(0, 77, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(3, 4, 1);

    // Reset on the 4th RUN cycle of 127*127: no done, no partial product.
    A = 7'd127; B = 7'd127; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    heldP = '0;
    heldFlag = 1'b0;
    checkResetState("midrun_reset");
    applyStimulus(2, 3, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, 127);
      rb = $urandom_range(0, 127);
      if (i % 10 == 3) rb = 0;
      if (i % 10 == 7) rb = $urandom_range(0, 3);
      applyStimulus(ra, rb, (i % 8) == 5);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
